// File: rtl/rbs64_seq.sv
// rbs64_seq: multi-cycle ripple-borrow subtractor. It computes A - B - Bin one CHUNK-bit slice per clock, LSB slice first.
// Define RBS_SIGNED_OVERFLOW_EN to add the signed-overflow flag ovf_out.
module rbs64_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] DIFF_out,
    output logic             Bout_out,
    output logic             out_valid,
`ifdef RBS_SIGNED_OVERFLOW_EN
    output logic             ovf_out,
`endif
    input  logic             out_ready
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [WIDTH-1:0]        a_p0;
    logic [WIDTH-1:0]        b_p0;
    logic [WIDTH-1:0]        part_p0;
    logic                    borrow_p0;
    logic [CNT_W-1:0]        cnt_p0;

    logic [CHUNK-1:0]        a_sl;
    logic [CHUNK-1:0]        b_sl;
    logic [CHUNK:0]          sub_sl;
    logic [WIDTH-1:0]        part_full;

    // The top bit of the (CHUNK+1)-bit result is the borrow out of this slice.
    function automatic logic [CHUNK:0] slice_sub(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             bin);
        return {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    endfunction

    // Only one slice is subtracted per cycle. The borrow between slices is always registered.
    always_comb begin
        a_sl      = a_p0[int'(cnt_p0) * CHUNK +: CHUNK];
        b_sl      = b_p0[int'(cnt_p0) * CHUNK +: CHUNK];
        sub_sl    = slice_sub(a_sl, b_sl, borrow_p0);
        part_full = part_p0;
        part_full[int'(cnt_p0) * CHUNK +: CHUNK] = sub_sl[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            DIFF_out  <= '0;
            Bout_out  <= 1'b0;
            a_p0      <= '0;
            b_p0      <= '0;
            part_p0   <= '0;
            borrow_p0 <= 1'b0;
            cnt_p0    <= '0;
`ifdef RBS_SIGNED_OVERFLOW_EN
            ovf_out   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_p0      <= A_in;
                        b_p0      <= B_in;
                        borrow_p0 <= Bin_in;
                        cnt_p0    <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    part_p0   <= part_full;
                    borrow_p0 <= sub_sl[CHUNK];
                    cnt_p0    <= cnt_p0 + CNT_W'(1);
                    // The results update only when the last slice completes.
                    if (cnt_p0 == LAST) begin
                        DIFF_out  <= part_full;
                        Bout_out  <= sub_sl[CHUNK];
                        out_valid <= 1'b1;
`ifdef RBS_SIGNED_OVERFLOW_EN
                        ovf_out   <= (a_p0[WIDTH-1] != b_p0[WIDTH-1]) &&
                                     (part_full[WIDTH-1] != a_p0[WIDTH-1]);
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rbs64_seq.sv
// Bench for rbs64_seq. A transaction-level model tracks the handshake and the results.
// The model is checked every cycle, and directed literal cases pin the model itself.
module tb_rbs64_seq;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] A_in = '0;
    logic [WIDTH-1:0] B_in = '0;
    logic             Bin_in = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] DIFF_out;
    logic             Bout_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef RBS_SIGNED_OVERFLOW_EN
    logic             ovf_out;
`endif

    rbs64_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset(reset), .A_in(A_in), .B_in(B_in), .Bin_in(Bin_in),
        .in_valid(in_valid), .in_ready(in_ready), .DIFF_out(DIFF_out),
        .Bout_out(Bout_out), .out_valid(out_valid),
`ifdef RBS_SIGNED_OVERFLOW_EN
        .ovf_out(ovf_out),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: the visible outputs plus the result that is still pending.
    logic             m_ready = 1'b1, m_valid = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
    logic [WIDTH-1:0] m_diff = '0;
    logic             p_bout = 1'b0, p_ovf = 1'b0;
    logic [WIDTH-1:0] p_diff = '0;
    int               m_left = 0;

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic bin);
        return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    endfunction

    always @(posedge clk) begin
        logic [WIDTH:0] r;
        if (reset) begin
            m_ready = 1'b1; m_valid = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0; m_left = 0;
        end else if (m_ready && in_valid) begin
            r      = ref_sub(A_in, B_in, Bin_in);
            p_diff = r[WIDTH-1:0];
            p_bout = r[WIDTH];
            p_ovf  = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (p_diff[WIDTH-1] != A_in[WIDTH-1]);
            m_ready = 1'b0;
            m_left  = NCHUNK;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_valid = 1'b1; m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("DIFF_out", DIFF_out, m_diff);
            chk("Bout_out", 64'(Bout_out), 64'(m_bout));
`ifdef RBS_SIGNED_OVERFLOW_EN
            chk("ovf_out", 64'(ovf_out), 64'(m_ovf));
`endif
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         output int lat);
        wait_ready();
        A_in = a; B_in = b; Bin_in = bin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 64'd1;
            3: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_diff", DIFF_out, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(64'd10, 64'd3, 1'b0, lat);
        chk("lat_10_3", 64'(lat), 64'(NCHUNK));
        chk("diff_10_3", DIFF_out, 64'd7);
        chk("bout_10_3", 64'(Bout_out), 64'd0);
        chk("busy_ready", 64'(in_ready), 64'd0);
        handshake();
        chk("after_hs_ready", 64'(in_ready), 64'd1);
        chk("after_hs_valid", 64'(out_valid), 64'd0);
        chk("held_diff", DIFF_out, 64'd7);

        do_op(64'd0, 64'd1, 1'b0, lat);
        chk("diff_0_1", DIFF_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bout_0_1", 64'(Bout_out), 64'd1);
        handshake();

        do_op(64'h0000_0001_0000_0000, 64'd0, 1'b1, lat);
        chk("diff_xslice", DIFF_out, 64'h0000_0000_FFFF_FFFF);
        chk("bout_xslice", 64'(Bout_out), 64'd0);
        handshake();

        // Backpressure: a new request is already waiting while the result is held.
        wait_ready();
        A_in = 64'd5; B_in = 64'd2; Bin_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        A_in = 64'd9; B_in = 64'd9;
        wait_valid(lat);
        repeat (5) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_diff", DIFF_out, 64'd3);
            chk("bp_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", 64'(in_ready), 64'd0);
        wait_valid(lat);
        chk("diff_9_9", DIFF_out, 64'd0);
        chk("bout_9_9", 64'(Bout_out), 64'd0);
        handshake();

        // Reset on the second RUN edge aborts the operation.
        wait_ready();
        A_in = 64'd100; B_in = 64'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_diff", DIFF_out, 64'd0);
        chk("abort_bout", 64'(Bout_out), 64'd0);
        repeat (8) begin
            chk("abort_no_pulse", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

`ifdef RBS_SIGNED_OVERFLOW_EN
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat);
        chk("ovf_diff", DIFF_out, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("ovf_bout", 64'(Bout_out), 64'd0);
        chk("ovf_set", 64'(ovf_out), 64'd1);
        handshake();
        do_op(64'd5, 64'd3, 1'b0, lat);
        chk("ovf_clear", 64'(ovf_out), 64'd0);
        handshake();
`endif

        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            A_in      = pick();
            B_in      = pick();
            Bin_in    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rbs64_seq.md
Name: rbs64_seq

Overview:
- Multi-cycle ripple-borrow subtractor: computes DIFF = A − B − Bin over WIDTH bits, one CHUNK-bit slice per clock, LSB slice first.
- Inverse arithmetic companion to the 64-bit ripple carry adder; sits on the same datapath test harness.
- Operands are accepted and results are delivered over valid/ready handshakes, so it can be chained with registered adder stages.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 16, bits subtracted per cycle. WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- A_in  input  WIDTH  minuend.
- B_in  input  WIDTH  subtrahend.
- Bin_in  input  1  borrow-in.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- DIFF_out  output  WIDTH  (A − B − Bin) mod 2^WIDTH.
- Bout_out  output  1  final borrow; 1 iff A < B + Bin (unsigned).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset (sampled on rising clk): state=IDLE, in_ready=1, out_valid=0, DIFF_out=0, Bout_out=0, internal operand, partial and borrow registers=0, slice counter=0.
- Reset mid-operation aborts the transaction with no out_valid pulse. Reset has priority over all other events.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch A_in, B_in, Bin_in; borrow=Bin_in; cnt=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge computes {b_out, slice} = A[cnt] − B[cnt] − borrow over CHUNK+1 bits, where slice index cnt selects bits [cnt*CHUNK +: CHUNK].
  - Write the slice into the partial register; borrow ← b_out; cnt ← cnt+1.
  - On the edge processing slice NCHUNK−1: DIFF_out ← completed partial (including the final slice), Bout_out ← b_out, out_valid ← 1, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - On an edge with out_ready=1: out_valid ← 0, go to IDLE.
- Latency: acceptance edge = edge 0; out_valid is high after edge NCHUNK (4 edges at the defaults).
- Throughput: one result per NCHUNK+2 cycles minimum (accept, NCHUNK RUN edges, handoff).
- DIFF_out and Bout_out change only on completion. They hold their last result through IDLE/RUN and after out_valid drops, until the next completion.
- No operand pass-through: in_valid or operand changes outside IDLE are ignored. Operands are captured only at acceptance.
- Borrow propagates across slice boundaries via the borrow register, never combinationally between slices. The critical path is one CHUNK-bit subtract.
- Wrap-around: results are modulo 2^WIDTH and the borrow is reported on Bout_out. No saturation.

Optional Feature:
- Macro: RBS_SIGNED_OVERFLOW_EN.
- Defined:
  - Adds output port ovf_out (1 bit), reset 0, updated with DIFF_out on completion.
  - ovf_out = (A[WIDTH−1] ≠ B[WIDTH−1]) & (DIFF[WIDTH−1] ≠ A[WIDTH−1]), using the latched operands; Bin is included in DIFF.
  - Held like DIFF_out.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then A=10, B=3, Bin=0, in_valid for 1 cycle → out_valid high 4 edges after acceptance; DIFF=7, Bout=0; in_ready=0 until out_ready handshake, then 1.
- A=0, B=1, Bin=0 → DIFF=0xFFFF_FFFF_FFFF_FFFF, Bout=1 (borrow ripples through all 4 slices).
- A=0x0000_0001_0000_0000, B=0, Bin=1 → DIFF=0x0000_0000_FFFF_FFFF, Bout=0 (cross-slice borrow stops at slice 2).
- Backpressure: complete A=5, B=2 with out_ready=0 for 5 cycles while in_valid=1 with A=9, B=9 → out_valid and DIFF=3 held, in_ready=0. After out_ready=1 for one edge: IDLE, then 9−9 accepted → DIFF=0, Bout=0.
- Reset asserted on 2nd RUN edge of A=100, B=1 → next cycle: in_ready=1, out_valid=0, DIFF_out=0, Bout_out=0; no out_valid pulse afterwards.
- With RBS_SIGNED_OVERFLOW_EN: A=0x8000_0000_0000_0000, B=1, Bin=0 → DIFF=0x7FFF_FFFF_FFFF_FFFF, Bout=0, ovf_out=1. Then A=5, B=3 → ovf_out=0.
